// File: rtl/mem_arb_pkg.sv
// Shared types and grant-selection helper for mem_arbiter.
//
// Contents:
//   port_id_t  - requester identifier (0 = core fetch/load/store, 1 = loader/debug)
//   pick_t     - result of grant selection {valid, port}
//   mem_req_t  - one memory access {we, addr, wdata} at the default bus widths
//   pick_port  - combinational round-robin choice with bounded bursts
package mem_arb_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef logic port_id_t;
  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } pick_t;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

  // A lone requester always wins. Under contention the current owner keeps the
  // port until its burst budget is spent, then the other side gets it.
  function automatic pick_t pick_port(input logic     req0,
                                      input logic     req1,
                                      input port_id_t last_owner,
                                      input logic     burst_at_max);
    pick_t p;
    p.valid = req0 | req1;
    if (req0 && req1)
      p.port = burst_at_max ? ~last_owner : last_owner;
    else if (req1)
      p.port = PORT1;
    else
      p.port = PORT0;
    return p;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single unified memory port.
//
// Port 0 is the multicycle core, port 1 the loader/debug master. At most one
// access is issued per cycle; read data returns one cycle later, tagged to the
// port that issued it. Bounded-burst round-robin prevents starvation.
//
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   m0_/m1_req,we,addr,wdata - requester inputs, held stable until granted
//   m0_/m1_gnt               - access issued this cycle (combinational)
//   m0_/m1_rvalid,rdata      - read return, one cycle after a granted read
//   mem_we,addr,wdata        - memory request bus (zero when idle)
//   mem_rdata                - memory read data, one cycle after the address
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int             BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0]  BURST_ONE = BW'(1);

  port_id_t      last_owner;
  logic [BW-1:0] burst_cnt;
  logic          rd_pend;
  port_id_t      rd_port;

  pick_t         pick;

  // Grant selection and request mux (issue stage)
  always_comb begin
    pick      = pick_port(m0_req, m1_req, last_owner, burst_cnt == BURST_MAX);
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pick.valid) begin
      if (pick.port == PORT1) begin
        m1_gnt    = 1'b1;
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end else begin
        m0_gnt    = 1'b1;
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= PORT0;
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
      rd_port    <= PORT0;
    end else if (!pick.valid) begin
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
    end else begin
      if (pick.port == last_owner) begin
        // Saturate rather than wrap so a long solo run still yields at once
        // when the other side starts requesting.
        if (burst_cnt != BURST_MAX)
          burst_cnt <= burst_cnt + BURST_ONE;
      end else begin
        last_owner <= pick.port;
        burst_cnt  <= BURST_ONE;
      end
      rd_pend <= !mem_we;
      if (!mem_we)
        rd_port <= pick.port;
    end
  end

  // Read return stage: rvalid is masked during reset so a read granted just
  // before reset never surfaces.
  assign m0_rvalid = rd_pend && (rd_port == PORT0) && !reset;
  assign m1_rvalid = rd_pend && (rd_port == PORT1) && !reset;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each stimulus cycle pushes its hand-computed
// expected outputs into a queue; a monitor pops one entry per cycle at the
// falling edge and compares.
import mem_arb_pkg::*;

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       tag;
    bit       g0, g1, v0, v1;
    mem_req_t bus;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", nm, tag, act, req);
    end
  endtask

  // Monitor: one expectation per stimulus cycle, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("m0_gnt",    e.tag, 32'(m0_gnt),    32'(e.g0));
      chk("m1_gnt",    e.tag, 32'(m1_gnt),    32'(e.g1));
      chk("mem_we",    e.tag, 32'(mem_we),    32'(e.bus.we));
      chk("mem_addr",  e.tag, mem_addr,       e.bus.addr);
      chk("mem_wdata", e.tag, mem_wdata,      e.bus.wdata);
      chk("m0_rvalid", e.tag, 32'(m0_rvalid), 32'(e.v0));
      chk("m1_rvalid", e.tag, 32'(m1_rvalid), 32'(e.v1));
      chk("m0_rdata",  e.tag, m0_rdata,       e.rd);
      chk("m1_rdata",  e.tag, m1_rdata,       e.rd);
    end
  end

  int step_no = 0;

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic [31:0] mrd,
                      input bit eg0, input bit eg1, input bit ev0, input bit ev1);
    exp_t e;
    reset = rst;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    mem_rdata = mrd;
    e.tag = step_no;
    e.g0 = eg0; e.g1 = eg1; e.v0 = ev0; e.v1 = ev1;
    e.rd = mrd;
    if (eg0)      e.bus = '{we: w0, addr: a0, wdata: d0};
    else if (eg1) e.bus = '{we: w1, addr: a1, wdata: d1};
    else          e.bus = '{we: 1'b0, addr: '0, wdata: '0};
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst, input logic [31:0] mrd, input bit ev0, input bit ev1);
    step(rst, 0, 0, 0, 0, 0, 0, 0, 0, mrd, 0, 0, ev0, ev1);
  endtask

  task automatic both_rd(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] mrd,
                         input bit eg1, input bit ev0, input bit ev1);
    step(0, 1, 0, a0, 0, 1, 0, a1, 0, mrd, !eg1, eg1, ev0, ev1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    @(posedge clk);
    #1;

    // Reset: everything idle and zero
    idle(1, 32'h0, 0, 0);
    idle(1, 32'h0, 0, 0);

    // Lone m0 read of 0x10, data returns next cycle
    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    idle(0, 32'hDEADBEEF, 1, 0);

    // Continuous contention: bursts of four, rvalid follows the grant
    for (int k = 0; k < 10; k++)
      both_rd(32'h100 + 32'(k * 4), 32'h200 + 32'(k * 4), 32'hA000_0000 + 32'(k),
              gseq[k] == 1, (k != 0) && gseq[(k == 0) ? 0 : k - 1] == 0,
              (k != 0) && gseq[(k == 0) ? 0 : k - 1] == 1);
    idle(0, 32'hA000_000A, 1, 0);

    // Lone m1 write: bus carries it, no read return
    step(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'h1234_5678, 32'h0, 0, 1, 0, 0);
    idle(0, 32'h5555_5555, 0, 0);

    // Alternating reads: m0 then m1, returns on separate cycles
    step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 32'h1111_1111, 0, 1, 1, 0);
    idle(0, 32'h2222_2222, 0, 1);

    // Contention, idle gap clears the burst, owner (m1) then gets four more
    both_rd(32'h300, 32'h400, 32'h0, 1, 0, 0);
    both_rd(32'h304, 32'h404, 32'h3, 1, 0, 1);
    idle(0, 32'h4, 0, 1);
    both_rd(32'h308, 32'h408, 32'h5, 1, 0, 0);
    both_rd(32'h30C, 32'h40C, 32'h6, 1, 0, 1);
    both_rd(32'h310, 32'h410, 32'h7, 1, 0, 1);
    both_rd(32'h314, 32'h414, 32'h8, 1, 0, 1);
    both_rd(32'h318, 32'h418, 32'h9, 0, 0, 1);
    idle(0, 32'hA, 1, 0);

    // Reset right after a granted m0 read: no return before or after reset
    step(0, 0, 0, 0, 0, 1, 1, 32'h44, 32'hCAFE_F00D, 32'h0, 0, 1, 0, 0);
    step(0, 1, 0, 32'h50, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    idle(1, 32'hBAD0_0001, 0, 0);
    idle(0, 32'hBAD0_0002, 0, 0);

    // Reset clears ownership: m1 owned the port, after reset m0 wins contention
    step(0, 0, 0, 0, 0, 1, 0, 32'h60, 0, 32'h0, 0, 1, 0, 0);
    idle(1, 32'hBAD0_0003, 0, 0);
    idle(0, 32'h0, 0, 0);
    both_rd(32'h70, 32'h74, 32'h0, 0, 0, 0);
    idle(0, 32'h7777_0000, 1, 0);

    // Burst counter saturates: six solo m0 reads, then m1 wins immediately
    for (int k = 0; k < 6; k++)
      step(0, 1, 0, 32'h80 + 32'(k * 4), 0, 0, 0, 0, 0, 32'hB000_0000 + 32'(k), 1, 0, k != 0, 0);
    both_rd(32'h98, 32'h9C, 32'hB000_0006, 1, 1, 0);
    idle(0, 32'hB000_0007, 0, 1);

    @(negedge clk);
    #1;
    chk("queue_drained", -1, 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
